// File: rtl/present80_pkg.sv
// Shared definitions for the PRESENT-80 Wishbone controller and its round unit:
// register map, control/status bit positions, FSM encoding, widths and the S-box.
package present80_pkg;

  localparam int STATE_W = 64;
  localparam int KEY_W   = 80;
  localparam int RND_W   = 5;

  // Byte offsets inside the 64-byte register window
  localparam logic [5:0] OFS_CTRL   = 6'h00;
  localparam logic [5:0] OFS_STATUS = 6'h04;
  localparam logic [5:0] OFS_PT_LO  = 6'h08;
  localparam logic [5:0] OFS_PT_HI  = 6'h0C;
  localparam logic [5:0] OFS_KEY0   = 6'h10;
  localparam logic [5:0] OFS_KEY1   = 6'h14;
  localparam logic [5:0] OFS_KEY2   = 6'h18;
  localparam logic [5:0] OFS_CT_LO  = 6'h1C;
  localparam logic [5:0] OFS_CT_HI  = 6'h20;

  // CTRL / STATUS bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_RND_LSB = 4;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_ROUND = 2'd1,
    FSM_FINAL = 2'd2
  } fsm_e;

  // PRESENT 4-bit S-box
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // Merge a 32-bit write into an existing word under per-byte enables
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/present80_wb_ctrl_if.sv
// Wishbone slave bus bundle (caravel MGMT port naming) with master/slave views.
interface present80_wb_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/present80_round.sv
// One PRESENT-80 round, purely combinational: addRoundKey, S-box layer, pLayer,
// plus the key-schedule step keyed by the current round counter.
module present80_round
  import present80_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [RND_W-1:0]   ctr_i,
  output logic [STATE_W-1:0] state_o,
  output logic [KEY_W-1:0]   key_o
);

  logic [STATE_W-1:0] ark_s;
  logic [STATE_W-1:0] sb_s;
  logic [KEY_W-1:0]   rot_s;

  // Data path: mix in round key, substitute nibbles, then bit-permute
  always_comb begin
    ark_s = state_i ^ key_i[79:16];
    sb_s  = 64'h0;
    for (int n = 0; n < 16; n++) begin
      sb_s[4*n +: 4] = sbox4(ark_s[4*n +: 4]);
    end
    state_o = 64'h0;
    for (int i = 0; i < 63; i++) begin
      state_o[(i * 16) % 63] = sb_s[i];
    end
    state_o[63] = sb_s[63];
  end

  // Key schedule: rotate left by 61, S-box the top nibble, fold in the counter
  always_comb begin
    rot_s         = {key_i[18:0], key_i[79:19]};
    key_o         = rot_s;
    key_o[79:76]  = sbox4(rot_s[79:76]);
    key_o[19:15]  = rot_s[19:15] ^ ctr_i;
  end

endmodule

// File: rtl/present80_wb_ctrl.sv
// Wishbone register front-end and round sequencer for a PRESENT-80 round unit
// that lives outside this block. One round per cycle, then a key whitening.
module present80_wb_ctrl
  import present80_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          NROUNDS  = 31
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  present80_wb_ctrl_if.slave  wbs,
  output logic [2:0]          irq,
  output logic [15:0]         io_out,
  output logic [15:0]         io_oeb,
  output logic [STATE_W-1:0]  rnd_state_o,
  output logic [KEY_W-1:0]    rnd_key_o,
  output logic [RND_W-1:0]    rnd_ctr_o,
  input  logic [STATE_W-1:0]  rnd_state_i,
  input  logic [KEY_W-1:0]    rnd_key_i
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NROUNDS);

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] pt_q, pt_d;
  logic [KEY_W-1:0]   kin_q, kin_d;
  logic [STATE_W-1:0] ct_q, ct_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic               irq_q, irq_d;

  logic        sel_s, acc_s, wr_s, busy_s, start_s, w1c_s;
  logic [5:0]  ofs_s;
  logic [3:0]  wsel_s;
  logic [31:0] rdata_s, merged_s;
  logic        unused_s;

  assign busy_s   = (fsm_q != FSM_IDLE);
  assign sel_s    = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                    (wbs.wbs_adr_i[31:6] == BASE_ADR[31:6]);
  // An access completes on the edge that raises ack; back-to-back selects
  // therefore see at most one ack every two cycles.
  assign acc_s    = sel_s & ~ack_q;
  assign wr_s     = acc_s & wbs.wbs_we_i;
  assign ofs_s    = {wbs.wbs_adr_i[5:2], 2'b00};
  // Operand registers are frozen while an encryption runs
  assign wsel_s   = wbs.wbs_sel_i & {4{~busy_s}};
  assign unused_s = ^wbs.wbs_adr_i[1:0];

  // Read mux over the register window; unmapped offsets read zero
  always_comb begin
    rdata_s = 32'h0;
    case (ofs_s)
      OFS_CTRL:   rdata_s[CTRL_IRQ_EN] = irq_en_q;
      OFS_STATUS: begin
        rdata_s[STAT_BUSY]                = busy_s;
        rdata_s[STAT_DONE]                = done_q;
        rdata_s[STAT_RND_LSB +: RND_W]    = round_q;
      end
      OFS_PT_LO:  rdata_s = pt_q[31:0];
      OFS_PT_HI:  rdata_s = pt_q[63:32];
      OFS_KEY0:   rdata_s = kin_q[31:0];
      OFS_KEY1:   rdata_s = kin_q[63:32];
      OFS_KEY2:   rdata_s = {16'h0, kin_q[79:64]};
      OFS_CT_LO:  rdata_s = ct_q[31:0];
      OFS_CT_HI:  rdata_s = ct_q[63:32];
      default:    rdata_s = 32'h0;
    endcase
  end

  // Register writes: operand updates, IRQ enable, START pulse and DONE clear
  always_comb begin
    pt_d     = pt_q;
    kin_d    = kin_q;
    irq_en_d = irq_en_q;
    start_s  = 1'b0;
    w1c_s    = 1'b0;
    merged_s = 32'h0;
    if (wr_s) begin
      case (ofs_s)
        OFS_CTRL: begin
          start_s  = wbs.wbs_sel_i[0] & wbs.wbs_dat_i[CTRL_START];
          irq_en_d = wbs.wbs_sel_i[0] ? wbs.wbs_dat_i[CTRL_IRQ_EN] : irq_en_q;
        end
        OFS_STATUS: w1c_s = wbs.wbs_sel_i[0] & wbs.wbs_dat_i[STAT_DONE];
        OFS_PT_LO: begin
          merged_s    = byte_merge(pt_q[31:0], wbs.wbs_dat_i, wsel_s);
          pt_d[31:0]  = merged_s;
        end
        OFS_PT_HI: begin
          merged_s    = byte_merge(pt_q[63:32], wbs.wbs_dat_i, wsel_s);
          pt_d[63:32] = merged_s;
        end
        OFS_KEY0: begin
          merged_s     = byte_merge(kin_q[31:0], wbs.wbs_dat_i, wsel_s);
          kin_d[31:0]  = merged_s;
        end
        OFS_KEY1: begin
          merged_s     = byte_merge(kin_q[63:32], wbs.wbs_dat_i, wsel_s);
          kin_d[63:32] = merged_s;
        end
        OFS_KEY2: begin
          merged_s     = byte_merge({16'h0, kin_q[79:64]}, wbs.wbs_dat_i, wsel_s);
          kin_d[79:64] = merged_s[15:0];
        end
        default: merged_s = 32'h0;
      endcase
    end else begin
      merged_s = 32'h0;
    end
  end

  // Round sequencer: load on START, 31 round updates, then whitening into CT
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    ct_d    = ct_q;
    done_d  = done_q & ~w1c_s;
    case (fsm_q)
      FSM_IDLE: begin
        if (start_s) begin
          state_d = pt_q;
          key_d   = kin_q;
          round_d = 5'd1;
          done_d  = 1'b0;
          fsm_d   = FSM_ROUND;
        end else begin
          fsm_d   = FSM_IDLE;
        end
      end
      FSM_ROUND: begin
        state_d = rnd_state_i;
        key_d   = rnd_key_i;
        if (round_q >= LAST_RND) begin
          round_d = round_q;
          fsm_d   = FSM_FINAL;
        end else begin
          round_d = round_q + 5'd1;
          fsm_d   = FSM_ROUND;
        end
      end
      FSM_FINAL: begin
        ct_d   = state_q ^ key_q[79:16];
        done_d = 1'b1;
        fsm_d  = FSM_IDLE;
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  // Bus response and interrupt, computed from next-state values so irq tracks DONE
  always_comb begin
    ack_d = acc_s;
    dat_d = (acc_s & ~wbs.wbs_we_i) ? rdata_s : 32'h0;
    irq_d = done_d & irq_en_d;
  end

  // State registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fsm_q    <= FSM_IDLE;
      pt_q     <= 64'h0;
      kin_q    <= 80'h0;
      ct_q     <= 64'h0;
      state_q  <= 64'h0;
      key_q    <= 80'h0;
      round_q  <= 5'd0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      irq_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      pt_q     <= pt_d;
      kin_q    <= kin_d;
      ct_q     <= ct_d;
      state_q  <= state_d;
      key_q    <= key_d;
      round_q  <= round_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign irq           = {2'b00, irq_q};
  assign io_out        = {14'h0, done_q, busy_s};
  assign io_oeb        = 16'hFFFC;
  assign rnd_state_o   = state_q;
  assign rnd_key_o     = key_q;
  assign rnd_ctr_o     = round_q;

endmodule

// File: doc/present80_wb_ctrl.md
Name: present80_wb_ctrl

Overview:
- Wishbone-slave controller that sequences a one-round-per-cycle PRESENT-80 round datapath through 31 rounds plus a final key whitening.
- Holds the plaintext, key and ciphertext registers, plus control/status, so the management SoC can run an encryption by register writes and poll or take an interrupt.
- Sits inside the user project, directly on the caravel MGMT Wishbone port and the user IRQ lines.

Parameters:
- BASE_ADR, 32'h3000_0000, Wishbone base address; the block decodes a 64-byte window at this base.
- NROUNDS, 31, number of datapath round updates before final whitening (fixed by PRESENT; a parameter for test only).

Ports:
- wb_clk_i  in  1  block clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- irq  out  3  user interrupts; irq[0] = done & irq_en, irq[2:1] = 0
- io_out  out  16  io_out[0] = busy, io_out[1] = done, others 0
- io_oeb  out  16  bits [1:0] = 0 (driven); all others = 1
- rnd_state_o  out  64  current cipher state to round unit (registered)
- rnd_key_o  out  80  current round key register (registered)
- rnd_ctr_o  out  5  current round counter, 1..31
- rnd_state_i  in  64  next state from round unit (combinational)
- rnd_key_i  in  80  next key from round unit

Behaviour:
Register map (byte offset):
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (RW).
- 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-to-clear); bits[8:4] round counter (RO).
- 0x08 PT_LO, 0x0C PT_HI: plaintext, RW.
- 0x10 KEY0 = key[31:0], 0x14 KEY1 = key[63:32], 0x18 KEY2 = key[79:64] in bits[15:0]; all RW.
- 0x1C CT_LO, 0x20 CT_HI: ciphertext, RO.
- Other offsets in the window read 0 and ignore writes.

Wishbone rules:
- Select = cyc & stb & address inside the window.
- ack is asserted the cycle after select and only while ack is currently 0. This gives a single-cycle ack pulse with at most one ack per two cycles.
- Write and read data are sampled/driven with that ack.
- wbs_sel_i masks writes per byte.
- Writes to PT/KEY while BUSY are acked and dropped.
- Outside the window: no ack, and wbs_dat_o = 0.

FSM states: IDLE, ROUND, FINAL.
- IDLE: on the edge E0 that accepts a START=1 write, load state←PT and key←KEY, set round=1, clear DONE, go to ROUND.
- ROUND, edges E1..E31: state←rnd_state_i, key←rnd_key_i, round←round+1. After the update at round=31, go to FINAL.
- FINAL, edge E32: CT←state ^ key[79:16], DONE←1, go to IDLE.
- BUSY = (FSM != IDLE). DONE first reads 1 after E32 (32 cycles after the start edge).
- START while BUSY is ignored (acked) and has no effect on DONE.
- The round counter is 5 bits and saturates at its terminal value. It never wraps to 0 inside an operation.

Boundary conditions:
- A DONE write-1-to-clear on the same edge as the FINAL set: set wins, DONE = 1.
- START and DONE-clear in one write in IDLE: START clears DONE anyway.
- Reset at any time: FSM=IDLE; all registers (PT, KEY, CT, state, key, round, IRQ_EN, DONE) = 0; ack = 0; irq = 0. An in-flight encryption is abandoned.
- Reset values of outputs:
  - wbs_ack_o = 0, wbs_dat_o = 0, irq = 0, io_out = 0.
  - rnd_* outputs = 0; rnd_ctr_o = 0 in IDLE after reset.
  - io_oeb as specified above (it is constant).

Decomposition:
- Shared package present80_pkg holds:
  - register offsets (CTRL, STATUS, PT_LO … CT_HI);
  - CTRL/STATUS bit positions;
  - the FSM state enum;
  - widths STATE_W=64, KEY_W=80, RND_W=5.
- One sub-module, present80_round (combinational: addRoundKey, S-box layer, pLayer, key schedule using rnd_ctr).
  - It is instantiated beside this controller by the project top, not inside it, so the controller is testable with a model round unit.

Test Plan:
- PT=0, KEY=0, START → DONE after exactly 32 cycles from the start edge; CT_HI:CT_LO = 5579C138_7B228445.
- PT=0, KEY=FFFF…F (80 bits) → CT = E72C46C0_F5945049. Then PT=FFFF_FFFF_FFFF_FFFF, KEY=0 → CT = A112FFC7_2F68417B.
- PT=all-F, KEY=all-F with IRQ_EN=1 → irq[0] rises with DONE, CT = 3333DCD3_213210D2. W1C STATUS bit1 → irq[0]=0.
- START issued at round 10, plus a KEY0 write while BUSY → result still matches the original operands; round field never exceeds 31.
- Reset asserted at round 15 → BUSY=0, DONE=0, CT=0 immediately. A new START completes correctly.
- Byte-enable write wbs_sel_i=4'b0010, data 0x0000AB00, to PT_LO=0 → PT_LO reads 0x0000AB00. An unmapped offset 0x3C reads 0 with ack. An address outside the window gets no ack.
